// File: rtl/awmc_plant_monitor_if.sv
// Signal bundle between the washing machine controller and the plant monitor.
// The master side drives controller commands and sensors; the slave side is the monitor.
interface awmc_plant_monitor_if #(
  parameter int unsigned LEVEL_W = 8
);
  logic [2:0]         stage;
  logic               input_valve;
  logic               output_drain;
  logic               done;
  logic               lid;
  logic               clear_fault;
  logic [LEVEL_W-1:0] water_level;
  logic               level_full;
  logic               level_empty;
  logic               lid_lock;
  logic               fault;
  logic [2:0]         fault_code;
  logic [7:0]         cycle_count;
  logic               busy;

  modport master (
    output stage, input_valve, output_drain, done, lid, clear_fault,
    input  water_level, level_full, level_empty, lid_lock, fault, fault_code, cycle_count, busy
  );

  modport slave (
    input  stage, input_valve, output_drain, done, lid, clear_fault,
    output water_level, level_full, level_empty, lid_lock, fault, fault_code, cycle_count, busy
  );
endinterface

// File: rtl/awmc_plant_monitor.sv
// Appliance-side plant monitor: models drum water level, drives the lid interlock,
// latches the first protocol/plant fault and counts fault-free wash cycles.
module awmc_plant_monitor #(
  parameter int unsigned LEVEL_W       = 8,
  parameter int unsigned FILL_RATE     = 16,
  parameter int unsigned DRAIN_RATE    = 32,
  parameter int unsigned MAX_LEVEL     = 200,
  parameter int unsigned FULL_THRESH   = 32,
  parameter int unsigned RESIDUE_MAX   = 0,
  parameter int unsigned STAGE_TIMEOUT = 64,
  parameter int unsigned TO_W          = 7
) (
  input logic                 clk,
  input logic                 reset,
  awmc_plant_monitor_if.slave mon
);

  localparam logic [2:0] StFill  = 3'b000;
  localparam logic [2:0] StWash  = 3'b001;
  localparam logic [2:0] StRinse = 3'b010;
  localparam logic [2:0] StSpin  = 3'b011;
  localparam logic [2:0] StIdle  = 3'b111;

  localparam logic [LEVEL_W:0]   FillRate  = (LEVEL_W+1)'(FILL_RATE);
  localparam logic [LEVEL_W:0]   DrainRate = (LEVEL_W+1)'(DRAIN_RATE);
  localparam logic [LEVEL_W:0]   MaxWide   = (LEVEL_W+1)'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] MaxLevel  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] FullLevel = LEVEL_W'(FULL_THRESH);
  localparam logic [LEVEL_W-1:0] Residue   = LEVEL_W'(RESIDUE_MAX);
  localparam logic [TO_W-1:0]    Timeout   = TO_W'(STAGE_TIMEOUT);

  typedef enum logic [1:0] {MonIdle, MonRun, MonDone, MonFault} mon_state_e;

  mon_state_e         state_q;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W:0]   level_sum, level_diff;
  logic               full_q, empty_q;
  logic [2:0]         stage_q;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               timeout_hit;
  logic [2:0]         fault_det;
  logic               lock_stage;
  logic               lid_lock_q, fault_q, busy_q;
  logic [2:0]         fault_code_q;
  logic [7:0]         cycle_count_q;

  // Next drum level: widened arithmetic, clamped to [0, MAX_LEVEL]; conflict holds level.
  always_comb begin
    level_sum  = {1'b0, level_q} + FillRate;
    level_diff = {1'b0, level_q} - DrainRate;
    level_d    = level_q;
    if (mon.input_valve && !mon.output_drain) begin
      level_d = (level_sum > MaxWide) ? MaxLevel : level_sum[LEVEL_W-1:0];
    end else if (mon.output_drain && !mon.input_valve) begin
      level_d = level_diff[LEVEL_W] ? '0 : level_diff[LEVEL_W-1:0];
    end
  end

  // Stage persistence counter; IDLE is a legal pause and restarts the count.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((mon.stage != stage_q) || (mon.stage == StIdle)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    timeout_hit = (to_cnt_d >= Timeout);
  end

  // Fault classification, lowest code wins.
  always_comb begin
    lock_stage = (mon.stage == StWash) || (mon.stage == StRinse) || (mon.stage == StSpin);
    if (mon.input_valve && mon.output_drain) begin
      fault_det = 3'd1;
    end else if (mon.input_valve && (level_q == MaxLevel)) begin
      fault_det = 3'd2;
    end else if (mon.lid && (mon.stage == StSpin)) begin
      fault_det = 3'd3;
    end else if (timeout_hit) begin
      fault_det = 3'd4;
    end else if (mon.done && (level_q > Residue)) begin
      fault_det = 3'd5;
    end else begin
      fault_det = 3'd0;
    end
  end

  // Plant model registers run in every monitor state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      stage_q  <= StIdle;
      to_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      full_q   <= (level_d >= FullLevel);
      empty_q  <= (level_d == '0);
      stage_q  <= mon.stage;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Monitor FSM with registered interlock, fault and cycle outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= MonIdle;
      lid_lock_q    <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= 3'd0;
      cycle_count_q <= 8'd0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        MonIdle: begin
          lid_lock_q <= 1'b0;
          busy_q     <= 1'b0;
          if (mon.stage == StFill) begin
            state_q <= MonRun;
            busy_q  <= 1'b1;
          end
        end
        MonRun: begin
          if (fault_det != 3'd0) begin
            state_q      <= MonFault;
            fault_q      <= 1'b1;
            fault_code_q <= fault_det;
            lid_lock_q   <= 1'b0;
            busy_q       <= 1'b0;
          end else if (mon.done) begin
            state_q       <= MonDone;
            cycle_count_q <= cycle_count_q + 8'd1;
            lid_lock_q    <= 1'b0;
            busy_q        <= 1'b0;
          end else begin
            lid_lock_q <= lock_stage;
            busy_q     <= 1'b1;
          end
        end
        MonDone: begin
          state_q    <= MonIdle;
          lid_lock_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        MonFault: begin
          lid_lock_q <= 1'b0;
          busy_q     <= 1'b0;
          if (mon.clear_fault) begin
            state_q      <= MonIdle;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
          end
        end
        default: state_q <= MonIdle;
      endcase
    end
  end

  assign mon.water_level = level_q;
  assign mon.level_full  = full_q;
  assign mon.level_empty = empty_q;
  assign mon.lid_lock    = lid_lock_q;
  assign mon.fault       = fault_q;
  assign mon.fault_code  = fault_code_q;
  assign mon.cycle_count = cycle_count_q;
  assign mon.busy        = busy_q;

endmodule

// File: tb/tb_awmc_plant_monitor.sv
// Directed bench for awmc_plant_monitor with hand-computed expectations.
module tb_awmc_plant_monitor;

  localparam logic [2:0] StFill  = 3'b000;
  localparam logic [2:0] StWash  = 3'b001;
  localparam logic [2:0] StRinse = 3'b010;
  localparam logic [2:0] StSpin  = 3'b011;
  localparam logic [2:0] StStop  = 3'b100;
  localparam logic [2:0] StIdle  = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  awmc_plant_monitor_if #(.LEVEL_W(8)) mon_if ();

  awmc_plant_monitor dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon_if.slave)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 32'(mon_if.water_level), 0);
    chk({tag, "_empty"}, 32'(mon_if.level_empty), 1);
    chk({tag, "_full"}, 32'(mon_if.level_full), 0);
    chk({tag, "_lock"}, 32'(mon_if.lid_lock), 0);
    chk({tag, "_fault"}, 32'(mon_if.fault), 0);
    chk({tag, "_code"}, 32'(mon_if.fault_code), 0);
    chk({tag, "_count"}, 32'(mon_if.cycle_count), 0);
    chk({tag, "_busy"}, 32'(mon_if.busy), 0);
  endtask

  task automatic drive(input logic [2:0] stg, input logic v, input logic d, input logic dn,
                       input logic l, input logic clr);
    mon_if.stage        = stg;
    mon_if.input_valve  = v;
    mon_if.output_drain = d;
    mon_if.done         = dn;
    mon_if.lid          = l;
    mon_if.clear_fault  = clr;
  endtask

  initial begin
    reset = 1'b1;
    drive(StIdle, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state("rst");

    // Fill two cycles: first edge enters RUN and adds 16.
    drive(StFill, 1, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("fill_level", 32'(mon_if.water_level), 32);
    chk("fill_full", 32'(mon_if.level_full), 1);
    chk("fill_busy", 32'(mon_if.busy), 1);
    chk("fill_fault", 32'(mon_if.fault), 0);

    // WASH engages the interlock, then a valve/drain conflict.
    drive(StWash, 0, 0, 0, 0, 0);
    cyc();
    chk("wash_lock", 32'(mon_if.lid_lock), 1);
    drive(StWash, 1, 1, 0, 0, 0);
    cyc();
    chk("conf_fault", 32'(mon_if.fault), 1);
    chk("conf_code", 32'(mon_if.fault_code), 1);
    chk("conf_level", 32'(mon_if.water_level), 32);
    chk("conf_lock", 32'(mon_if.lid_lock), 0);
    drive(StWash, 0, 0, 0, 0, 1);
    cyc();
    chk("clr_fault", 32'(mon_if.fault), 0);
    chk("clr_code", 32'(mon_if.fault_code), 0);
    chk("clr_busy", 32'(mon_if.busy), 0);
    chk("clr_level", 32'(mon_if.water_level), 32);

    // Drain while idle, then overflow from empty.
    drive(StIdle, 0, 1, 0, 0, 0);
    cyc();
    chk("drain_level", 32'(mon_if.water_level), 0);
    chk("drain_empty", 32'(mon_if.level_empty), 1);
    drive(StFill, 1, 0, 0, 0, 0);
    repeat (12) cyc();
    chk("ovf_192", 32'(mon_if.water_level), 192);
    cyc();
    chk("ovf_clamp", 32'(mon_if.water_level), 200);
    chk("ovf_nofault", 32'(mon_if.fault), 0);
    cyc();
    chk("ovf_code", 32'(mon_if.fault_code), 2);
    chk("ovf_held", 32'(mon_if.water_level), 200);
    drive(StFill, 0, 0, 0, 0, 1);
    cyc();

    // Lid opened during SPIN.
    drive(StFill, 0, 0, 0, 0, 0);
    cyc();
    drive(StSpin, 0, 0, 0, 0, 0);
    cyc();
    chk("spin_lock", 32'(mon_if.lid_lock), 1);
    chk("spin_busy", 32'(mon_if.busy), 1);
    drive(StSpin, 0, 0, 0, 1, 0);
    cyc();
    chk("lid_code", 32'(mon_if.fault_code), 3);
    chk("lid_lock_drop", 32'(mon_if.lid_lock), 0);
    drive(StSpin, 0, 0, 0, 0, 1);
    cyc();
    // Lid and conflict together: conflict has the lower code.
    drive(StFill, 0, 0, 0, 0, 0);
    cyc();
    drive(StSpin, 1, 1, 0, 1, 0);
    cyc();
    chk("prio_code", 32'(mon_if.fault_code), 1);
    chk("prio_level", 32'(mon_if.water_level), 200);
    drive(StSpin, 0, 0, 0, 0, 1);
    cyc();

    // Stage timeout: the counter reads 0 on the edge that first samples WASH.
    drive(StFill, 0, 0, 0, 0, 0);
    cyc();
    drive(StWash, 0, 0, 0, 0, 0);
    repeat (64) cyc();
    chk("to_before", 32'(mon_if.fault), 0);
    cyc();
    chk("to_code", 32'(mon_if.fault_code), 4);
    chk("to_lock", 32'(mon_if.lid_lock), 0);
    drive(StWash, 0, 0, 0, 0, 1);
    cyc();

    // An IDLE pause restarts the timeout window.
    drive(StFill, 0, 0, 0, 0, 0);
    cyc();
    drive(StWash, 0, 0, 0, 0, 0);
    repeat (40) cyc();
    drive(StIdle, 0, 0, 0, 0, 0);
    cyc();
    drive(StWash, 0, 0, 0, 0, 0);
    repeat (64) cyc();
    chk("pause_fault", 32'(mon_if.fault), 0);
    chk("pause_busy", 32'(mon_if.busy), 1);

    // Drain to zero and finish this cycle: 200 -> 0 in 7 drains.
    drive(StRinse, 0, 1, 0, 0, 0);
    repeat (7) cyc();
    chk("end_level", 32'(mon_if.water_level), 0);
    drive(StStop, 0, 0, 1, 0, 0);
    cyc();
    chk("done1_count", 32'(mon_if.cycle_count), 1);
    chk("done1_busy", 32'(mon_if.busy), 0);
    chk("done1_fault", 32'(mon_if.fault), 0);
    drive(StIdle, 0, 0, 0, 0, 0);
    cyc();

    // Complete FILL->WASH->RINSE->SPIN->STOP cycle.
    drive(StFill, 1, 0, 0, 0, 0);
    cyc();
    cyc();
    drive(StWash, 0, 0, 0, 0, 0);
    cyc();
    drive(StRinse, 0, 0, 0, 0, 0);
    cyc();
    drive(StSpin, 0, 1, 0, 0, 0);
    cyc();
    chk("full_drained", 32'(mon_if.water_level), 0);
    drive(StStop, 0, 0, 0, 0, 0);
    cyc();
    drive(StStop, 0, 0, 1, 0, 0);
    cyc();
    chk("done2_count", 32'(mon_if.cycle_count), 2);
    chk("done2_fault", 32'(mon_if.fault), 0);
    drive(StIdle, 0, 0, 0, 0, 0);
    cyc();

    // Same cycle left with 16 units at done.
    drive(StFill, 1, 0, 0, 0, 0);
    cyc();
    drive(StWash, 0, 0, 0, 0, 0);
    cyc();
    drive(StRinse, 0, 0, 0, 0, 0);
    cyc();
    drive(StSpin, 0, 0, 0, 0, 0);
    cyc();
    drive(StStop, 0, 0, 0, 0, 0);
    cyc();
    drive(StStop, 0, 0, 1, 0, 0);
    cyc();
    chk("res_code", 32'(mon_if.fault_code), 5);
    chk("res_count", 32'(mon_if.cycle_count), 2);
    chk("res_level", 32'(mon_if.water_level), 16);
    drive(StIdle, 0, 0, 0, 0, 1);
    cyc();
    chk("res_clr", 32'(mon_if.fault), 0);

    // done while idle is ignored.
    drive(StIdle, 0, 0, 1, 0, 0);
    cyc();
    chk("idle_done_count", 32'(mon_if.cycle_count), 2);
    chk("idle_done_busy", 32'(mon_if.busy), 0);

    // Asynchronous reset in the middle of RINSE.
    drive(StFill, 1, 0, 0, 0, 0);
    cyc();
    cyc();
    drive(StRinse, 0, 0, 0, 0, 0);
    cyc();
    chk("rinse_lock", 32'(mon_if.lid_lock), 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("async");
    #2 reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/awmc_plant_monitor.md
Name: awmc_plant_monitor

Overview:
Appliance-side counterpart of the washing machine controller FSM. It consumes the controller's stage, valve and drain commands and models the drum water level. It drives the lid interlock, detects protocol and plant faults, and counts completed wash cycles. It sits between the controller outputs and the status/safety logic.

Parameters:
LEVEL_W, 8, width of water level register
FILL_RATE, 16, level increment per cycle with valve open
DRAIN_RATE, 32, level decrement per cycle with drain open
MAX_LEVEL, 200, physical drum capacity (saturation point)
FULL_THRESH, 32, level at or above which level_full asserts
RESIDUE_MAX, 0, max level tolerated when done asserts
STAGE_TIMEOUT, 64, max cycles a non-IDLE stage may persist unchanged
TO_W, 7, width of stage timeout counter

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
stage  in  3  controller stage: IDLE=111, FILL=000, WASH=001, RINSE=010, SPIN=011, STOP=100
input_valve  in  1  controller fill command
output_drain  in  1  controller drain command
done  in  1  controller cycle-complete pulse
lid  in  1  lid sensor, 1 = open
clear_fault  in  1  clears latched fault
water_level  out  LEVEL_W  modelled drum level
level_full  out  1  water_level >= FULL_THRESH
level_empty  out  1  water_level == 0
lid_lock  out  1  lid interlock engaged
fault  out  1  fault latched
fault_code  out  3  0 none, 1 valve/drain conflict, 2 overflow, 3 lid open in SPIN, 4 stage timeout, 5 residue at done
cycle_count  out  8  completed fault-free cycles, wraps 255->0
busy  out  1  monitor in RUN

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. All outputs are registered.
- Reset values: water_level=0, level_empty=1, every other output 0, FSM=MON_IDLE, timeout counter 0. Reset mid-cycle forces level to 0 (drum treated as drained).
- Latency: every output reflects inputs sampled on the previous edge, i.e. one cycle.
- Level update each cycle:
  - valve & !drain: level += FILL_RATE, saturating at MAX_LEVEL.
  - drain & !valve: level -= DRAIN_RATE, saturating at 0.
  - Both asserted: level held and conflict fault raised.
  - Neither asserted: level held.
  - Arithmetic is done at LEVEL_W+1 bits, then clamped.
- level_full and level_empty are derived from the next-state level (same edge as water_level).
- lid_lock = 1 when stage is WASH, RINSE or SPIN and FSM is MON_RUN; otherwise 0. It drops on entry to MON_FAULT.
- Stage timeout counter:
  - Resets to 0 whenever stage differs from the previous sampled stage, or stage == IDLE (pause is legal).
  - Otherwise increments, saturating.
  - Reaching STAGE_TIMEOUT raises fault 4.
- Fault conditions, evaluated only in MON_RUN:
  - 1: valve & drain asserted together.
  - 2: valve asserted while level == MAX_LEVEL.
  - 3: lid=1 while stage==SPIN.
  - 4: stage timeout reached.
  - 5: done=1 with level > RESIDUE_MAX.
  - Simultaneous faults: lowest code wins. The first fault is sticky; later faults are ignored until cleared.
- FSM:
  - MON_IDLE -> MON_RUN when stage==FILL.
  - MON_RUN -> MON_FAULT on any fault; fault takes precedence over done in the same cycle.
  - MON_RUN -> MON_DONE on done=1 with no fault; cycle_count increments on this transition.
  - MON_DONE -> MON_IDLE unconditionally after one cycle.
  - MON_FAULT -> MON_IDLE on clear_fault=1. This clears fault and fault_code; water_level is kept.
  - clear_fault in any other state has no effect.
- busy = (FSM == MON_RUN).
- Level modelling runs in all FSM states, so valves still move water while faulted.
- done asserted while in MON_IDLE is ignored.

Test Plan:
- Reset, then stage=FILL and valve=1 for 2 cycles -> water_level=32, level_full=1, busy=1, fault=0.
- Valve and drain both 1 for 1 cycle during WASH -> next cycle fault=1, fault_code=1, water_level unchanged, lid_lock=0; clear_fault -> fault=0, FSM in IDLE.
- Valve held 13 cycles from empty -> level 192 then clamps to 200. Valve still high on the 14th cycle -> fault_code=2.
- stage=SPIN, lid_lock=1, lid goes 1 -> next cycle fault_code=3, lid_lock=0. Variant: lid=1 in same cycle as valve/drain conflict -> fault_code=1.
- stage=WASH held 64 cycles with no change -> fault_code=4. Control: insert an IDLE pause at cycle 40, resume WASH -> no fault before 64 more cycles.
- Full cycle FILL->WASH->RINSE->SPIN->STOP, drained to 0, done pulse -> cycle_count=1, no fault. Repeat with level=16 at done -> fault_code=5, cycle_count unchanged. Async reset mid-RINSE -> all outputs at reset values immediately.
